// File: rtl/upe_serial_pkg.sv
// Shared definitions for the single-pin LSB-first word stream (receiver and
// future transmitter): FSM states, default geometry and the mid-bit offset.
package upe_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH      = 64;
  localparam int unsigned DEF_BIT_PERIOD = 1252;

  // Offset from the detected start edge to the middle of the start bit.
  function automatic int unsigned half_period(input int unsigned bit_period);
    return bit_period / 2;
  endfunction

endpackage

// File: rtl/serial_word_rx_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit; both flops
// reset to 0.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_word_rx.sv
// Bit-serial word receiver: start (high) / WIDTH data bits LSB first / stop
// (low) frames on din, delivered as whole words on a valid/ready port.
module serial_word_rx
  import upe_serial_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BIT_PERIOD = DEF_BIT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             framing_err,
  output logic             overrun,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int unsigned CW   = $clog2(BIT_PERIOD);
  localparam int unsigned BW   = $clog2(WIDTH + 1);
  localparam int unsigned HALF = half_period(BIT_PERIOD);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BP_M1   = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] WLAST   = BW'(WIDTH - 1);

  logic w_din_s;

  sync2 u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (din),
    .o_q   (w_din_s)
  );

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [BW-1:0]    r_bitidx;
  logic [BW-1:0]    w_bitidx_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_fe;
  logic             r_ovr;
  logic             w_shift_en;
  logic             w_frame_good;
  logic             w_frame_bad;
  logic             w_consume;
  logic             w_load;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitidx_nxt = r_bitidx;
    w_shift_en   = 1'b0;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt    = '0;
        w_bitidx_nxt = '0;
        if (w_din_s) w_state_nxt = START;
      end
      START: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt    = '0;
          w_bitidx_nxt = '0;
          w_state_nxt  = w_din_s ? DATA : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == BP_M1) begin
          w_shift_en   = 1'b1;
          w_cnt_nxt    = '0;
          w_bitidx_nxt = r_bitidx + 1'b1;
          if (r_bitidx == WLAST) w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == BP_M1) begin
          w_cnt_nxt    = '0;
          w_state_nxt  = IDLE;
          w_frame_good = ~w_din_s;
          w_frame_bad  = w_din_s;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitidx <= w_bitidx_nxt;
      // LSB arrives first, so after WIDTH right-shifts bit 0 sits at index 0.
      if (w_shift_en) r_shift <= {w_din_s, r_shift[WIDTH-1:1]};
    end
  end

  // Handshake: a word transfers on a cycle with out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer.
  assign w_consume = r_valid & out_ready;
  assign w_load    = w_frame_good & (~r_valid | w_consume);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_fe <= w_frame_bad;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (w_frame_good && r_valid && !out_ready) r_ovr <= 1'b1;
    end
  end

  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign framing_err = r_fe;
  assign overrun     = r_ovr;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed-plus-random bench for serial_word_rx at BIT_PERIOD=8, WIDTH=64;
// expected words and event times come from the frame rules, not the RTL.
module tb_serial_word_rx;
  import upe_serial_pkg::*;

  localparam int W    = 64;
  localparam int BP   = 8;
  localparam int HALF = BP / 2;
  // Cycles from the first clock edge that sees din high to out_valid.
  localparam int LAT  = 2 + HALF + (W + 1) * BP;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         framing_err;
  logic         overrun;
  logic         busy;
  state_t       dbg_state;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(W), .BIT_PERIOD(BP)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int cyc = 0;
  logic cap_ready = 1'b0;
  logic cap_rst   = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    cap_ready <= out_ready;
    cap_rst   <= rst;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_busy  = 1'b0;
  logic         prev_fe    = 1'b0;
  int load_cnt = 0, last_load_cyc = -1, stab_err = 0;
  int busy_rise = -1, busy_fall = -1;
  int fe_cnt = 0, fe_cyc = -1, fe_long = 0;

  always @(negedge clk) begin
    logic acc_last;
    acc_last = prev_valid && cap_ready;
    if (out_valid && (!prev_valid || acc_last)) begin
      got_q.push_back(out_data);
      load_cnt++;
      last_load_cyc = cyc;
    end
    if (prev_valid && !acc_last && !cap_rst && (!out_valid || out_data !== prev_data))
      stab_err++;
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    if (framing_err) begin
      fe_cnt++;
      fe_cyc = cyc;
      if (prev_fe) fe_long++;
    end
    prev_valid = out_valid;
    prev_data  = out_data;
    prev_busy  = busy;
    prev_fe    = framing_err;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : {W{1'bx}};
      check(tag, g, e);
    end
    check({tag, "_extra"}, W'(got_q.size()), W'(0));
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int t_start = 0;

  // Drives one frame; optionally pulses out_ready at bit-time index rdy_at,
  // or asserts rst for one cycle at index rst_at and abandons the frame.
  task automatic send_frame(input logic [W-1:0] word, input logic stop_val,
                            input int rdy_at, input int rst_at);
    logic [W+1:0] bits;
    bits = {stop_val, word, 1'b1};
    for (int j = 0; j < (W + 2) * BP; j++) begin
      @(negedge clk);
      if (j == 0) t_start = cyc + 1;
      din = bits[j / BP];
      if (j == rdy_at) out_ready = 1'b1;
      else if (rdy_at >= 0 && j == rdy_at + 1) out_ready = 1'b0;
      if (rst_at >= 0 && j == rst_at) rst = 1'b1;
      if (rst_at >= 0 && j == rst_at + 1) begin
        rst = 1'b0;
        din = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] w;
    int ts, l0, f0;

    repeat (3) @(negedge clk);
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_data", out_data, W'(0));
    check("rst_fe", W'(framing_err), W'(0));
    check("rst_ovr", W'(overrun), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    rst = 1'b0;
    idle(4);

    // good frame, ready held high: value and schedule
    out_ready = 1'b1;
    send_frame(64'h000000007F7DF7D7, 1'b0, -1, -1);
    ts = t_start;
    exp_q.push_back(64'h000000007F7DF7D7);
    idle(3);
    check("good_load_cyc", W'(last_load_cyc), W'(ts + LAT));
    check("good_busy_rise", W'(busy_rise), W'(ts + 2));
    check("good_busy_fall", W'(busy_fall), W'(ts + LAT));
    check("good_valid_low", W'(out_valid), W'(0));
    drain_check("good_word");

    // back-to-back random frames
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      exp_q.push_back(w);
      send_frame(w, 1'b0, -1, -1);
    end
    idle(3);
    drain_check("rand_word");

    // backpressure: hold for 100 cycles, then release
    out_ready = 1'b0;
    send_frame(64'h5555555555555555, 1'b0, -1, -1);
    exp_q.push_back(64'h5555555555555555);
    idle(100);
    check("bp_valid", W'(out_valid), W'(1));
    check("bp_data", out_data, 64'h5555555555555555);
    check("bp_stable", W'(stab_err), W'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", W'(out_valid), W'(0));
    out_ready = 1'b0;
    drain_check("bp_word");

    // overrun: second frame dropped while the first is held
    send_frame(64'h1, 1'b0, -1, -1);
    send_frame(64'h2, 1'b0, -1, -1);
    exp_q.push_back(64'h1);
    idle(3);
    check("ovr_data", out_data, 64'h1);
    check("ovr_flag", W'(overrun), W'(1));
    check("ovr_valid", W'(out_valid), W'(1));
    drain_check("ovr_word");
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("ovr_rst_valid", W'(out_valid), W'(0));
    check("ovr_rst_flag", W'(overrun), W'(0));

    // consume and load on the same edge
    send_frame(64'h1, 1'b0, -1, -1);
    send_frame(64'h2, 1'b0, LAT, -1);
    exp_q.push_back(64'h1);
    exp_q.push_back(64'h2);
    idle(3);
    check("cl_data", out_data, 64'h2);
    check("cl_ovr", W'(overrun), W'(0));
    check("cl_valid", W'(out_valid), W'(1));
    out_ready = 1'b1;
    idle(2);
    drain_check("cl_word");

    // start glitch: two cycles high
    l0 = load_cnt;
    f0 = fe_cnt;
    @(negedge clk) din = 1'b1;
    @(negedge clk) din = 1'b1;
    idle(12);
    check("gl_busy", W'(busy), W'(0));
    check("gl_state", W'(dbg_state), W'(IDLE));
    check("gl_loads", W'(load_cnt), W'(l0));
    check("gl_fe", W'(fe_cnt), W'(f0));

    // stop bit high
    send_frame({$urandom, $urandom}, 1'b1, -1, -1);
    ts = t_start;
    idle(12);
    check("fe_count", W'(fe_cnt), W'(f0 + 1));
    check("fe_width", W'(fe_long), W'(0));
    check("fe_cyc", W'(fe_cyc), W'(ts + LAT));
    check("fe_loads", W'(load_cnt), W'(l0));
    check("fe_valid", W'(out_valid), W'(0));

    // reset in the middle of data bit 30, then a clean frame
    send_frame({$urandom, $urandom}, 1'b0, -1, BP * 31 + HALF);
    check("mr_valid", W'(out_valid), W'(0));
    check("mr_data", out_data, W'(0));
    check("mr_busy", W'(busy), W'(0));
    check("mr_fe", W'(framing_err), W'(0));
    check("mr_ovr", W'(overrun), W'(0));
    check("mr_state", W'(dbg_state), W'(IDLE));
    idle(4);
    send_frame(64'hDEADBEEF00C0FFEE, 1'b0, -1, -1);
    ts = t_start;
    exp_q.push_back(64'hDEADBEEF00C0FFEE);
    idle(3);
    check("mr_load_cyc", W'(last_load_cyc), W'(ts + LAT));
    drain_check("mr_word");
    check("final_stable", W'(stab_err), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Bit-serial word receiver: the capture end of the single-pin, LSB-first word stream the design uses for result read-out. It samples one input pin at a fixed bit period, frames each word with a start and a stop bit, and assembles a WIDTH-bit word. It presents the word on a valid/ready port. It sits between a board GPIO, or a loop-back from the LED driver, and the operand registers of the multiplier datapath under test.

## Interface
- WIDTH, 64: data bits per frame.
- BIT_PERIOD, 1252: clocks per bit. At the 10 kHz oscillator this is about 125 ms per bit. Minimum 4.
- clk  in  1  system clock (10 kHz internal oscillator on target).
- rst  in  1  reset, synchronous, active-high.
- din  in  1  asynchronous serial line. Idle low.
- out_data  out  WIDTH  received word. Stable while out_valid is high.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- framing_err  out  1  one-cycle pulse: stop bit sampled high.
- overrun  out  1  sticky: a good frame was dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format on din: start bit (high, 1 period), then WIDTH data bits with bit 0 first, then stop bit (low, 1 period). Idle level is low.
- din passes through a 2-flop synchronizer. All logic uses the synchronized value din_s.
- Constant HALF = BIT_PERIOD/2, integer division.
- FSM states and transitions:
  - IDLE: cnt=0. When din_s==1, go to START.
  - START: cnt counts up. At cnt==HALF-1, sample din_s. If it is 1, go to DATA with cnt=0 and bitidx=0. If it is 0, the start was a glitch: go to IDLE with no outputs.
  - DATA: at cnt==BIT_PERIOD-1, shift reg[bitidx] <= din_s, reset cnt, and increment bitidx. After bit WIDTH-1, go to STOP with cnt=0.
  - STOP: at cnt==BIT_PERIOD-1, sample din_s.
    - If 0 (good frame): load out_data from the shift register and set out_valid. Exception: if out_valid is high and not consumed this cycle, keep the old word and set overrun.
    - If 1: pulse framing_err and discard the word.
    - Either way, go to IDLE.
- Handshake:
  - out_valid stays high until out_valid && out_ready.
  - out_data must not change while out_valid is high.
  - Consume and new-frame load in the same cycle: the new word loads, out_valid stays 1, overrun is not set.
- overrun clears only on rst.
- Width rules:
  - cnt is sized by $clog2(BIT_PERIOD).
  - bitidx is sized by $clog2(WIDTH+1).
  - No wrap-around occurs inside a frame. The counters reset per bit and per frame.

## Timing
- Reset values: state IDLE; out_data 0; out_valid 0; framing_err 0; overrun 0; busy 0; cnt 0; bitidx 0; synchronizer flops 0.
- rst has priority over everything.
  - rst mid-frame drops the partial word and returns the FSM to IDLE on the next edge.
  - rst with out_valid high clears it.
- din to din_s latency: 2 cycles. Let cycle D be the first cycle with din_s==1 seen in IDLE.
- Start check happens at D+HALF.
- Data bit k is sampled at D+HALF+(k+1)·BIT_PERIOD.
- Stop bit is sampled at D+HALF+(WIDTH+1)·BIT_PERIOD. out_valid or framing_err is visible on the following cycle.
- busy goes high at D+1 and low one cycle after the stop sample.
- A new start can be detected on the first cycle back in IDLE, so back-to-back frames need no gap beyond the stop bit.

## Structure
- Shared package upe_serial_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - defaults for WIDTH and BIT_PERIOD;
  - the HALF derivation.
- A future matching transmitter imports the same package.
- One sub-module: sync2, a generic 2-flop synchronizer with a reset value of 0.

## Test plan
All tests use BIT_PERIOD=8 and WIDTH=64.
- Good frame: send 64'h000000007F7DF7D7 with out_ready=1.
  - out_valid pulses once with that value, exactly 2+4+65·8 cycles after the start edge on din.
  - busy and the timing match the schedule above.
- Hold and backpressure: send 64'h5555555555555555 with out_ready=0.
  - out_valid stays high and out_data stays stable for 100 cycles.
  - Raising out_ready drops out_valid on the next edge.
- Overrun: send two frames, 64'h1 then 64'h2, with out_ready=0.
  - out_data stays 64'h1 and overrun=1.
  - Repeat with out_ready pulsed on the second frame's load cycle: out_data=64'h2 and overrun=0.
- Glitch and framing:
  - Drive din high for 2 cycles only: the FSM returns to IDLE, with no out_valid and no framing_err.
  - Send a frame with the stop bit high: a single-cycle framing_err, and out_valid stays 0.
- Reset mid-frame: assert rst for 1 cycle during data bit 30.
  - All outputs return to reset values.
  - A following good frame of 64'hDEADBEEF00C0FFEE is received correctly.
